// File: rtl/md_sequencer.sv
// Multi-cycle multiply/divide sequencer holding the MIPS HI/LO registers.
// The result is computed at issue into a shadow register and committed after a fixed latency.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_use,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(DIV_CYCLES) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_MUL = 2'd1,
    RUN_DIV = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   res_hi;
  logic [31:0]   res_lo;
  logic          commit_en;

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        div_safe;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;
  logic               is_arith;

  assign prod_s = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
  assign prod_u = {32'b0, src_a} * {32'b0, src_b};

  // A zero divisor is replaced so the divider never sees it; the result is discarded anyway.
  assign div_safe = (src_b == 32'd0) ? 32'd1 : src_b;
  assign quot_s   = $signed(src_a) / $signed(div_safe);
  assign rem_s    = $signed(src_a) % $signed(div_safe);
  assign quot_u   = src_a / div_safe;
  assign rem_u    = src_a % div_safe;

  assign is_arith = (md_op == 3'd0) || (md_op == 3'd1) || (md_op == 3'd2) || (md_op == 3'd3);
  assign busy     = (state != IDLE);
  assign stall    = d_md_use & (busy | (start & is_arith));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      hi        <= '0;
      lo        <= '0;
      res_hi    <= '0;
      res_lo    <= '0;
      commit_en <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (md_op)
              3'd0: begin
                {res_hi, res_lo} <= prod_s;
                commit_en        <= 1'b1;
                cnt              <= CW'(MULT_CYCLES);
                state            <= RUN_MUL;
              end
              3'd1: begin
                {res_hi, res_lo} <= prod_u;
                commit_en        <= 1'b1;
                cnt              <= CW'(MULT_CYCLES);
                state            <= RUN_MUL;
              end
              3'd2: begin
                res_hi    <= rem_s;
                res_lo    <= quot_s;
                commit_en <= (src_b != 32'd0);
                cnt       <= CW'(DIV_CYCLES);
                state     <= RUN_DIV;
              end
              3'd3: begin
                res_hi    <= rem_u;
                res_lo    <= quot_u;
                commit_en <= (src_b != 32'd0);
                cnt       <= CW'(DIV_CYCLES);
                state     <= RUN_DIV;
              end
              3'd4:    hi <= src_a;
              3'd5:    lo <= src_a;
              default: ;
            endcase
          end
        end
        RUN_MUL, RUN_DIV: begin
          // A start arriving here is a hazard-controller bug and is deliberately dropped.
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            if (commit_en) begin
              hi <= res_hi;
              lo <= res_lo;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// Directed bench for md_sequencer: latency, HI/LO results, stall, ignored starts and async abort.
module tb_md_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_md_use;
  logic        busy;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .d_md_use (d_md_use),
    .busy     (busy),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one op in the current cycle (caller is at a negedge), then counts busy cycles.
  // Returns at the negedge of the first non-busy cycle, so the next call is back-to-back.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int n;
    old_hi = hi;
    old_lo = lo;
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      check({name, "_hold_hi"}, hi, old_hi);
      check({name, "_hold_lo"}, lo, old_lo);
      n++;
      @(negedge clk);
    end
    check({name, "_busy_len"}, n, exp_n);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    $display("op %s a=%h b=%h busy_cycles=%0d hi=%h lo=%h", name, a, b, n, hi, lo);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    md_op    = 3'd7;
    src_a    = '0;
    src_b    = '0;
    d_md_use = 1'b0;

    // 1: reset
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_hi", hi, 0);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_stall", stall, 0);
    check("post_rst_hi", hi, 0);
    check("post_rst_lo", lo, 0);
    $display("op reset busy=%0b stall=%0b hi=%h lo=%h", busy, stall, hi, lo);

    // 2-3: back-to-back arithmetic
    run_op("mult",  3'd0, 32'hFFFFFFFF, 32'h2, 5,  32'hFFFFFFFF, 32'hFFFFFFFE);
    run_op("multu", 3'd1, 32'hFFFFFFFF, 32'h2, 5,  32'h00000001, 32'hFFFFFFFE);
    run_op("div",   3'd2, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("divu",  3'd3, 32'd7,        32'd2, 10, 32'd1,        32'd3);

    // 4: MTLO then divide by zero leaves HI/LO alone
    run_op("mtlo",  3'd5, 32'h12345678, 32'h0, 0,  32'd1,        32'h12345678);
    run_op("div0",  3'd2, 32'd5,        32'd0, 10, 32'd1,        32'h12345678);
    run_op("mthi",  3'd4, 32'hCAFEF00D, 32'h0, 0,  32'hCAFEF00D, 32'h12345678);

    // no-op with d_md_use must not stall and must not write
    d_md_use = 1'b1;
    start = 1'b1;
    md_op = 3'd6;
    src_a = 32'hDEADBEEF;
    #1;
    check("nop_stall", stall, 0);
    @(negedge clk);
    start = 1'b0;
    check("nop_busy", busy, 0);
    check("nop_hi", hi, 32'hCAFEF00D);
    check("nop_lo", lo, 32'h12345678);
    $display("op nop busy=%0b hi=%h lo=%h", busy, hi, lo);

    // 5: stall window and start pulsed while busy
    start = 1'b1;
    md_op = 3'd0;
    src_a = 32'd6;
    src_b = 32'd7;
    #1;
    check("stall_start", stall, 1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      check("stall_busy", busy, 1);
      check("stall_run", stall, 1);
      check("stall_hold_lo", lo, 32'h12345678);
      start = (i == 2);
      md_op = 3'd3;
      src_a = 32'd9;
      src_b = 32'd2;
      @(negedge clk);
    end
    start = 1'b0;
    check("stall_end_busy", busy, 0);
    check("stall_end", stall, 0);
    check("stall_mult_hi", hi, 32'd0);
    check("stall_mult_lo", lo, 32'd42);
    $display("op mult_stall a=6 b=7 hi=%h lo=%h stall=%0b", hi, lo, stall);
    d_md_use = 1'b0;

    // 6: async abort on the 3rd busy cycle
    start = 1'b1;
    md_op = 3'd3;
    src_a = 32'd100;
    src_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_pre_busy", busy, 1);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_hi", hi, 0);
    check("abort_lo", lo, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("abort_no_commit_lo", lo, 0);
      check("abort_no_commit_hi", hi, 0);
      check("abort_idle", busy, 0);
    end
    $display("op abort_divu busy=%0b hi=%h lo=%h", busy, hi, lo);
    run_op("mult34", 3'd0, 32'd3, 32'd4, 5, 32'd0, 32'd12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
